// File: rtl/wb_stage.sv
// MEM/WB pipeline register for TinyRISC-V: formats load data before the flops,
// drives the register-file write port one cycle later and counts retired instructions.
module wb_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      valid_i,
   input  logic                      reg_wr_en_i,
   input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_i,
   input  logic [DATA_WIDTH-1:0]     alu_result_i,
   input  logic                      is_load_i,
   input  logic [2:0]                load_funct3_i,
   input  logic [DATA_WIDTH-1:0]     mem_rd_data_i,
   input  logic                      hold_i,
   input  logic                      flush_i,
   output logic                      reg_wr_en_o,
   output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_o,
   output logic [DATA_WIDTH-1:0]     reg_wr_data_o,
   output logic                      wb_valid_o,
   output logic                      load_err_o,
   output logic [CNT_WIDTH-1:0]      instret_o
);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   logic                      valid_q, valid_d;
   logic                      wr_en_q, wr_en_d;
   logic [REG_ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic [DATA_WIDTH-1:0]     data_q,  data_d;
   logic                      err_q,   err_d;
   logic [CNT_WIDTH-1:0]      instret_q, instret_d;

   logic [1:0]            off;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  load_bad;
   logic                  wb_valid;

   // Load extraction: pick the addressed byte/half out of the aligned word.
   always_comb begin
      off       = alu_result_i[1:0];
      byte_sel  = mem_rd_data_i[{off, 3'b000} +: 8];
      half_sel  = off[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];
      load_data = '0;
      load_bad  = 1'b0;
      case (load_funct3_i)
         F3_LB:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
         F3_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
         F3_LH: begin
            load_bad  = off[0];
            load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
         end
         F3_LHU: begin
            load_bad  = off[0];
            load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
         end
         F3_LW: begin
            load_bad  = (off != 2'b00);
            load_data = mem_rd_data_i;
         end
         default: load_bad = 1'b1;
      endcase
   end

   assign wb_valid = valid_q & ~err_q;

   // Flush beats hold; a held stage re-presents the same write every cycle.
   always_comb begin
      valid_d   = valid_q;
      wr_en_d   = wr_en_q;
      addr_d    = addr_q;
      data_d    = data_q;
      err_d     = err_q;
      instret_d = instret_q;
      if (flush_i) begin
         valid_d = 1'b0;
         err_d   = 1'b0;
      end else if (!hold_i) begin
         valid_d = valid_i;
         wr_en_d = reg_wr_en_i;
         addr_d  = reg_wr_addr_i;
         err_d   = valid_i & is_load_i & load_bad;
         if (!is_load_i)
            data_d = alu_result_i;
         else if (load_bad)
            data_d = '0;
         else
            data_d = load_data;
      end
      // The leaving instruction retires only on the edge that releases it.
      if (wb_valid && !hold_i)
         instret_d = instret_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
         instret_q <= '0;
      end else begin
         valid_q   <= valid_d;
         wr_en_q   <= wr_en_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         err_q     <= err_d;
         instret_q <= instret_d;
      end
   end

   assign wb_valid_o    = wb_valid;
   assign load_err_o    = valid_q & err_q;
   assign reg_wr_en_o   = wb_valid & wr_en_q & (addr_q != '0);
   assign reg_wr_addr_o = addr_q;
   assign reg_wr_data_o = data_q;
   assign instret_o     = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: table of load/write vectors fed through a
// scoreboard, plus hold, flush, async reset and 4-bit counter wrap sequences.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i, reg_wr_en_i, is_load_i, hold_i, flush_i;
   logic [4:0]  reg_wr_addr_i;
   logic [31:0] alu_result_i, mem_rd_data_i;
   logic [2:0]  load_funct3_i;

   logic        reg_wr_en_o, wb_valid_o, load_err_o;
   logic [4:0]  reg_wr_addr_o;
   logic [31:0] reg_wr_data_o;
   logic [63:0] instret_o;

   logic        we4, wbv4, err4;
   logic [4:0]  addr4;
   logic [31:0] data4;
   logic [3:0]  instret4;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .reg_wr_en_i(reg_wr_en_i),
      .reg_wr_addr_i(reg_wr_addr_i), .alu_result_i(alu_result_i), .is_load_i(is_load_i),
      .load_funct3_i(load_funct3_i), .mem_rd_data_i(mem_rd_data_i), .hold_i(hold_i),
      .flush_i(flush_i), .reg_wr_en_o(reg_wr_en_o), .reg_wr_addr_o(reg_wr_addr_o),
      .reg_wr_data_o(reg_wr_data_o), .wb_valid_o(wb_valid_o), .load_err_o(load_err_o),
      .instret_o(instret_o));

   wb_stage #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .reg_wr_en_i(reg_wr_en_i),
      .reg_wr_addr_i(reg_wr_addr_i), .alu_result_i(alu_result_i), .is_load_i(is_load_i),
      .load_funct3_i(load_funct3_i), .mem_rd_data_i(mem_rd_data_i), .hold_i(hold_i),
      .flush_i(flush_i), .reg_wr_en_o(we4), .reg_wr_addr_o(addr4),
      .reg_wr_data_o(data4), .wb_valid_o(wbv4), .load_err_o(err4),
      .instret_o(instret4));

   typedef struct {
      logic        valid;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] alu;
      logic        is_load;
      logic [2:0]  f3;
      logic [31:0] mem;
      logic        exp_we;
      logic        exp_wbv;
      logic        exp_err;
      logic [31:0] exp_data;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        wbv;
      logic        err;
      logic [63:0] instret;
   } exp_t;

   localparam logic [31:0] MEM = 32'h80FF_7F01;
   localparam int NV = 18;

   vec_t        vecs [NV];
   exp_t        sb_q [$];
   exp_t        last;
   logic [63:0] model_cnt;
   int          checks = 0;
   int          errors = 0;
   int          txn    = 0;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb_q.size() == 0) begin
         cmp("scoreboard_empty", 64'd1, 64'd0);
         return;
      end
      e = sb_q.pop_front();
      cmp("reg_wr_en", {63'd0, reg_wr_en_o}, {63'd0, e.we});
      cmp("wb_valid",  {63'd0, wb_valid_o},  {63'd0, e.wbv});
      cmp("load_err",  {63'd0, load_err_o},  {63'd0, e.err});
      cmp("instret",   instret_o, e.instret);
      cmp("instret4",  {60'd0, instret4}, {60'd0, e.instret[3:0]});
      cmp("reg_wr_en4", {63'd0, we4}, {63'd0, e.we});
      if (e.wbv || e.err)
         cmp("reg_wr_data", {32'd0, reg_wr_data_o}, {32'd0, e.data});
      if (e.wbv)
         cmp("reg_wr_addr", {59'd0, reg_wr_addr_o}, {59'd0, e.addr});
      $display("txn %0d: we=%b addr=%0d data=%h wbv=%b err=%b instret=%0d",
               txn, reg_wr_en_o, reg_wr_addr_o, reg_wr_data_o, wb_valid_o,
               load_err_o, instret_o);
      txn++;
   endtask

   task automatic apply(input vec_t v, input logic h, input logic f);
      exp_t e;
      valid_i       = v.valid;
      reg_wr_en_i   = v.we;
      reg_wr_addr_i = v.addr;
      alu_result_i  = v.alu;
      is_load_i     = v.is_load;
      load_funct3_i = v.f3;
      mem_rd_data_i = v.mem;
      hold_i        = h;
      flush_i       = f;
      if (last.wbv && !h)
         model_cnt = model_cnt + 64'd1;
      if (f) begin
         e     = last;
         e.we  = 1'b0;
         e.wbv = 1'b0;
         e.err = 1'b0;
      end else if (h) begin
         e = last;
      end else begin
         e.we   = v.exp_we;
         e.addr = v.addr;
         e.data = v.exp_data;
         e.wbv  = v.exp_wbv;
         e.err  = v.exp_err;
      end
      e.instret = model_cnt;
      sb_q.push_back(e);
      last = e;
      @(posedge clk);
      #1;
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 5'd5,  32'h1234_5678, 1'b0, 3'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'h1234_5678};
      vecs[1]  = '{1'b1, 1'b1, 5'd6,  32'h0000_0003, 1'b1, 3'd0, MEM,   1'b1, 1'b1, 1'b0, 32'hFFFF_FF80};
      vecs[2]  = '{1'b1, 1'b1, 5'd7,  32'h0000_0003, 1'b1, 3'd4, MEM,   1'b1, 1'b1, 1'b0, 32'h0000_0080};
      vecs[3]  = '{1'b1, 1'b1, 5'd8,  32'h0000_0002, 1'b1, 3'd1, MEM,   1'b1, 1'b1, 1'b0, 32'hFFFF_80FF};
      vecs[4]  = '{1'b1, 1'b1, 5'd9,  32'h0000_0000, 1'b1, 3'd5, MEM,   1'b1, 1'b1, 1'b0, 32'h0000_7F01};
      vecs[5]  = '{1'b1, 1'b1, 5'd10, 32'h0000_0000, 1'b1, 3'd2, MEM,   1'b1, 1'b1, 1'b0, 32'h80FF_7F01};
      vecs[6]  = '{1'b1, 1'b1, 5'd11, 32'h0000_1002, 1'b1, 3'd2, MEM,   1'b0, 1'b0, 1'b1, 32'h0000_0000};
      vecs[7]  = '{1'b1, 1'b1, 5'd12, 32'h0000_0001, 1'b1, 3'd1, MEM,   1'b0, 1'b0, 1'b1, 32'h0000_0000};
      vecs[8]  = '{1'b1, 1'b1, 5'd13, 32'h0000_0000, 1'b1, 3'd3, MEM,   1'b0, 1'b0, 1'b1, 32'h0000_0000};
      vecs[9]  = '{1'b1, 1'b1, 5'd0,  32'h0000_0055, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0055};
      vecs[10] = '{1'b0, 1'b1, 5'd14, 32'h0000_0099, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0000};
      vecs[11] = '{1'b1, 1'b1, 5'd15, 32'h0000_0001, 1'b1, 3'd0, MEM,   1'b1, 1'b1, 1'b0, 32'h0000_007F};
      vecs[12] = '{1'b1, 1'b1, 5'd16, 32'h0000_0002, 1'b1, 3'd4, MEM,   1'b1, 1'b1, 1'b0, 32'h0000_00FF};
      vecs[13] = '{1'b1, 1'b0, 5'd17, 32'h0000_ABCD, 1'b0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h0000_ABCD};
      vecs[14] = '{1'b0, 1'b1, 5'd18, 32'h0000_0000, 1'b1, 3'd7, MEM,   1'b0, 1'b0, 1'b0, 32'h0000_0000};
      vecs[15] = '{1'b1, 1'b1, 5'd19, 32'h0000_0002, 1'b1, 3'd5, MEM,   1'b1, 1'b1, 1'b0, 32'h0000_80FF};
      vecs[16] = '{1'b1, 1'b1, 5'd20, 32'h0000_0000, 1'b1, 3'd1, MEM,   1'b1, 1'b1, 1'b0, 32'h0000_7F01};
      vecs[17] = '{1'b1, 1'b1, 5'd21, 32'h0000_0000, 1'b1, 3'd6, MEM,   1'b0, 1'b0, 1'b1, 32'h0000_0000};

      rst_n = 1'b0;
      valid_i = 1'b0; reg_wr_en_i = 1'b0; reg_wr_addr_i = '0; alu_result_i = '0;
      is_load_i = 1'b0; load_funct3_i = '0; mem_rd_data_i = '0; hold_i = 1'b0; flush_i = 1'b0;
      last = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 64'd0};
      model_cnt = 64'd0;

      #12;
      cmp("rst_we",   {63'd0, reg_wr_en_o}, 64'd0);
      cmp("rst_addr", {59'd0, reg_wr_addr_o}, 64'd0);
      cmp("rst_data", {32'd0, reg_wr_data_o}, 64'd0);
      cmp("rst_wbv",  {63'd0, wb_valid_o}, 64'd0);
      cmp("rst_err",  {63'd0, load_err_o}, 64'd0);
      cmp("rst_cnt",  instret_o, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table sweep: writes, load extraction, errors, x0, bubbles.
      for (int i = 0; i < NV; i++)
         apply(vecs[i], 1'b0, 1'b0);
      apply(vecs[10], 1'b0, 1'b0);

      // Hold for three cycles with changing inputs, then release.
      apply(vecs[5], 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++)
         apply(vecs[i], 1'b1, 1'b0);
      apply(vecs[10], 1'b0, 1'b0);
      apply(vecs[10], 1'b0, 1'b0);

      // Flush wins over hold; then flush alone.
      apply(vecs[0], 1'b0, 1'b0);
      apply(vecs[4], 1'b1, 1'b1);
      apply(vecs[0], 1'b0, 1'b0);
      apply(vecs[4], 1'b0, 1'b1);

      // Asynchronous reset mid-cycle while a write is presented.
      apply(vecs[0], 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      cmp("arst_we",   {63'd0, reg_wr_en_o}, 64'd0);
      cmp("arst_wbv",  {63'd0, wb_valid_o}, 64'd0);
      cmp("arst_data", {32'd0, reg_wr_data_o}, 64'd0);
      cmp("arst_addr", {59'd0, reg_wr_addr_o}, 64'd0);
      cmp("arst_cnt",  instret_o, 64'd0);
      sb_q.delete();
      last = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 64'd0};
      model_cnt = 64'd0;
      @(negedge clk);
      rst_n = 1'b1;

      // Drive the 4-bit counter to 15, then retire one more.
      apply(vecs[0], 1'b0, 1'b0);
      for (int k = 0; k < 20 && model_cnt[3:0] != 4'hF; k++)
         apply(vecs[0], 1'b0, 1'b0);
      apply(vecs[10], 1'b0, 1'b0);
      cmp("wrap4", {60'd0, instret4}, 64'd0);
      cmp("wrap64", instret_o, 64'd16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- MEM/WB pipeline register plus write-back formatting for TinyRISC-V.
- Captures each instruction leaving the MEM stage and extracts and sign- or zero-extends load data.
- Drives the register file write port (write enable, address, data) one cycle later.
- Maintains a retired-instruction counter and flags load alignment or encoding errors.

Parameters:
- DATA_WIDTH, 32, datapath and register width.
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 64, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  MEM stage presents a real instruction this cycle.
- reg_wr_en_i  in  1  instruction writes rd.
- reg_wr_addr_i  in  REG_ADDR_WIDTH  rd index.
- alu_result_i  in  DATA_WIDTH  ALU result; for loads, the effective address.
- is_load_i  in  1  instruction is a load.
- load_funct3_i  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_rd_data_i  in  DATA_WIDTH  aligned 32-bit word read from data memory.
- hold_i  in  1  pipeline stall; freeze the stage.
- flush_i  in  1  kill the instruction entering the stage.
- reg_wr_en_o  out  1  register file write enable.
- reg_wr_addr_o  out  REG_ADDR_WIDTH  register file write address.
- reg_wr_data_o  out  DATA_WIDTH  register file write data.
- wb_valid_o  out  1  stage holds a valid, error-free instruction.
- load_err_o  out  1  held instruction is a misaligned or illegal load.
- instret_o  out  CNT_WIDTH  count of retired instructions.

Behaviour:
- Clock and reset: single clock; reset is asynchronous and active-low (rst_n).
- Reset values (all registers): valid_q=0, wr_en_q=0, addr_q=0, data_q=0, err_q=0, instret=0.
  - Therefore reg_wr_en_o=0, reg_wr_addr_o=0, reg_wr_data_o=0, wb_valid_o=0, load_err_o=0, instret_o=0.
  - Reset asserted mid-operation drops the in-flight instruction immediately; it is never written.
- Latency: one cycle. An instruction accepted at edge N drives the write port during cycle N..N+1.
- The register file forwards same-cycle writes, so no extra bypass is needed here.
- Capture priority at each rising edge:
  1. flush_i=1: valid_q<=0 and err_q<=0. Flush wins over hold. Other fields are don't-care.
  2. hold_i=1: all stage registers keep their value.
  3. Otherwise: capture the inputs; valid_q<=valid_i.
- Load formatting is done before the register, so outputs come straight from flops. Let off=alu_result_i[1:0].
  - LB/LBU: byte mem_rd_data_i[8*off+7 : 8*off]; sign- or zero-extended.
  - LH/LHU: half at off[1] (low half if off[1]=0); sign- or zero-extended. off[0]=1 is misaligned.
  - LW: full word. off!=0 is misaligned.
  - funct3 011/110/111 with is_load_i: illegal.
  - Non-load: data_q<=alu_result_i.
- Error case (misaligned or illegal load with valid_i):
  - err_q<=1, data_q<=0.
  - The instruction is captured but never written and never counted.
- Output decode:
  - wb_valid_o = valid_q & ~err_q.
  - load_err_o = valid_q & err_q.
  - reg_wr_en_o = wb_valid_o & wr_en_q & (addr_q!=0). An x0 destination never raises the write enable.
  - reg_wr_addr_o = addr_q; reg_wr_data_o = data_q, driven whenever valid.
- While hold_i=1 with valid_q=1, the write is re-presented every held cycle. This is idempotent.
- Retired-instruction counter:
  - instret increments by 1 at an edge where wb_valid_o=1 and hold_i=0, so a held instruction is counted exactly once.
  - x0-destination instructions and non-writing instructions (stores, branches) are counted.
  - Wraps from all-ones to 0 with no flag.
- valid_i=0 when captured gives a bubble: no write, no count, load_err_o=0.

Test Plan:
- Write path: valid_i=1, reg_wr_en_i=1, addr=5, non-load, alu_result_i=32'h1234_5678 → next cycle reg_wr_en_o=1, reg_wr_addr_o=5, reg_wr_data_o=32'h1234_5678; instret_o goes 0→1 at the following edge.
- Load extraction: mem_rd_data_i=32'h80FF_7F01.
  - LB off=3 → 32'hFFFF_FF80.
  - LBU off=3 → 32'h0000_0080.
  - LH off=2 → 32'hFFFF_80FF.
  - LHU off=0 → 32'h0000_7F01.
  - LW off=0 → 32'h80FF_7F01.
- Errors: LW with alu_result_i=32'h1002, LH with off=1, and funct3=3 each give load_err_o=1, reg_wr_en_o=0, wb_valid_o=0, instret unchanged.
- x0 and bubble handling:
  - rd=0 with reg_wr_en_i=1 → reg_wr_en_o=0, wb_valid_o=1, instret +1.
  - valid_i=0 → all write outputs 0.
- Hold and flush:
  - Capture an instruction, then hold_i=1 for 3 cycles while the inputs change → outputs stay constant and instret increments only once, after hold drops.
  - hold_i=1 and flush_i=1 together → wb_valid_o=0 next cycle.
- Reset and wrap:
  - Assert rst_n=0 asynchronously mid-cycle while reg_wr_en_o=1 → all outputs 0 immediately, before the next clock edge.
  - Force instret to all-ones (CNT_WIDTH=4 build, 15), then retire one instruction → instret_o=0.
